// File: rtl/seq_mult_ctrl_if.sv
// Handshake/bus bundle for the sequential shift-and-add multiplier.
// The master drives start/a/b and sees busy/done/product.
// Handshake: start is a request that is accepted only on a clock edge
// where the slave is idle. busy is high while the iterations run. done
// pulses for one cycle, and product is valid from that cycle until the
// next done. There is no back-pressure and no queueing.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [1:0]           dbg_state;  // registered FSM state, for observation

  modport master (
    output start, a, b,
    input  busy, done, product, dbg_state
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, dbg_state
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: one ripple-carry adder chain built from
// RCA_4bit slices is reused for WIDTH add/shift iterations.

// 4-bit ripple-carry adder slice.
module RCA_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [4:0] c;

  // Full-adder ripple across the four bit positions.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[4];
endmodule

module seq_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_mult_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int NRCA  = WIDTH / 4;

  // Reject widths the 4-bit slice chain cannot build.
  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("seq_mult_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic [NRCA:0]        carry;
  logic                 c_out;

  assign addend   = mq_q[0] ? mcand_q : '0;
  assign carry[0] = 1'b0;
  assign c_out    = carry[NRCA];

  for (genvar gi = 0; gi < NRCA; gi++) begin : g_rca
    RCA_4bit u_rca (
      .a_i    (acc_q[4*gi +: 4]),
      .b_i    (addend[4*gi +: 4]),
      .cin_i  (carry[gi]),
      .s_o    (sum[4*gi +: 4]),
      .cout_o (carry[gi+1])
    );
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state: capture in IDLE, add/shift in RUN, single-cycle DONE.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.a;
          mq_d    = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // {acc, mq} <= {carry, sum, mq} >> 1; the carry becomes acc MSB.
        acc_d = {c_out, sum[WIDTH-1:1]};
        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = {c_out, sum, mq_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.product   = product_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: WIDTH=4 and WIDTH=8 instances side by side,
// a transaction-level reference model per instance, directed cases and
// randomized traffic.
module tb_seq_mult_ctrl;
  localparam int W4 = 4;
  localparam int W8 = 8;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   done_cnt4 = 0;
  int   done_cnt8 = 0;

  seq_mult_ctrl_if #(.WIDTH(W4)) bus4 ();
  seq_mult_ctrl_if #(.WIDTH(W8)) bus8 ();

  seq_mult_ctrl #(.WIDTH(W4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  seq_mult_ctrl #(.WIDTH(W8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helper ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: an accepted request occupies WIDTH busy cycles and
  // one done cycle; the product a*b appears on entering the done cycle.
  // ph = 0 idle, 1..W busy cycle number, W+1 done cycle.
  int               ph4, ph8;
  logic [15:0]      pend4, pend8;
  logic [15:0]      expp4, expp8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph4 <= 0; pend4 <= '0; expp4 <= '0;
    end else if (ph4 == 0) begin
      if (bus4.start) begin
        ph4   <= 1;
        pend4 <= 16'(bus4.a) * 16'(bus4.b);
      end
    end else if (ph4 == W4 + 1) begin
      ph4 <= 0;
    end else begin
      ph4 <= ph4 + 1;
      if (ph4 == W4) expp4 <= pend4;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph8 <= 0; pend8 <= '0; expp8 <= '0;
    end else if (ph8 == 0) begin
      if (bus8.start) begin
        ph8   <= 1;
        pend8 <= 16'(bus8.a) * 16'(bus8.b);
      end
    end else if (ph8 == W8 + 1) begin
      ph8 <= 0;
    end else begin
      ph8 <= ph8 + 1;
      if (ph8 == W8) expp8 <= pend8;
    end
  end

  // ---------------- per-cycle compare (scoreboard) ----------------
  always @(negedge clk) begin
    chk("busy4",    32'(bus4.busy),    32'(ph4 >= 1 && ph4 <= W4));
    chk("done4",    32'(bus4.done),    32'(ph4 == W4 + 1));
    chk("product4", 32'(bus4.product), 32'(expp4[7:0]));
    chk("busy8",    32'(bus8.busy),    32'(ph8 >= 1 && ph8 <= W8));
    chk("done8",    32'(bus8.done),    32'(ph8 == W8 + 1));
    chk("product8", 32'(bus8.product), 32'(expp8));
    if (bus4.done) done_cnt4++;
    if (bus8.done) done_cnt8++;
  end

  // ---------------- driver tasks ----------------
  // One request on the selected instance; checks done latency and product.
  task automatic run_op(input bit is8, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string nm);
    int lat;
    int w;
    w = is8 ? W8 : W4;
    @(negedge clk);
    if (is8) begin bus8.start = 1'b1; bus8.a = a; bus8.b = b; end
    else     begin bus4.start = 1'b1; bus4.a = a[3:0]; bus4.b = b[3:0]; end
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= w + 4; i++) begin
      @(negedge clk);
      if (i == 1) begin bus4.start = 1'b0; bus8.start = 1'b0; end
      if ((is8 && bus8.done) || (!is8 && bus4.done)) begin lat = i; break; end
    end
    chk({nm, "_lat"}, 32'(lat), 32'(w + 1));
    chk({nm, "_prod"}, is8 ? 32'(bus8.product) : 32'(bus4.product), 32'(exp));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int t_done[3];
    int k;
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    idle_cycles(2);
    chk("rst_busy4", 32'(bus4.busy), 32'd0);
    chk("rst_done4", 32'(bus4.done), 32'd0);
    chk("rst_prod4", 32'(bus4.product), 32'd0);
    chk("rst_prod8", 32'(bus8.product), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Max operands, WIDTH=4.
    run_op(1'b0, 8'hF, 8'hF, 16'h00E1, "ff4");
    idle_cycles(1);

    // A*3, then zero multiplicand with product held from the previous run.
    run_op(1'b0, 8'hA, 8'h3, 16'h001E, "a3");
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'h0; bus4.b = 4'h9;
    @(posedge clk);
    for (int i = 1; i <= W4; i++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      chk("hold_1e", 32'(bus4.product), 32'h1E);
    end
    @(negedge clk);
    chk("z9_done", 32'(bus4.done), 32'd1);
    chk("z9_prod", 32'(bus4.product), 32'h00);
    run_op(1'b0, 8'h7, 8'h0, 16'h0000, "70");
    idle_cycles(1);

    // start during busy is ignored; operands changed after acceptance.
    d0 = done_cnt4;
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'h5; bus4.b = 4'h6;
    @(posedge clk);
    @(negedge clk); bus4.start = 1'b0; bus4.a = 4'h1; bus4.b = 4'h1;
    @(negedge clk); bus4.start = 1'b1; bus4.a = 4'hF; bus4.b = 4'hF;
    @(negedge clk); bus4.start = 1'b0; bus4.a = 4'h9; bus4.b = 4'h9;
    idle_cycles(8);
    chk("ign_prod", 32'(bus4.product), 32'h1E);
    chk("ign_ndone", 32'(done_cnt4 - d0), 32'd1);

    // Asynchronous reset in busy cycle 3.
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'hC; bus4.b = 4'hB;
    @(posedge clk);
    @(negedge clk); bus4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus4.busy), 32'd0);
    chk("arst_done", 32'(bus4.done), 32'd0);
    chk("arst_prod", 32'(bus4.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 8'h2, 8'h3, 16'h0006, "post_rst");
    idle_cycles(1);

    // WIDTH=8: max operands and a carry across the slice boundary.
    run_op(1'b1, 8'hFF, 8'hFF, 16'hFE01, "ff8");
    idle_cycles(1);
    run_op(1'b1, 8'h80, 8'h02, 16'h0100, "80x02");
    idle_cycles(1);

    // start held high: back-to-back runs every WIDTH+2 cycles.
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'h3; bus4.b = 4'h5;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (bus4.done) begin
        t_done[k] = cyc;
        chk("hold_prod", 32'(bus4.product), 32'h0F);
        k++;
      end
    end
    bus4.start = 1'b0;
    chk("hold_runs", 32'(k), 32'd3);
    if (k == 3) begin
      chk("hold_gap1", 32'(t_done[1] - t_done[0]), 32'(W4 + 2));
      chk("hold_gap2", 32'(t_done[2] - t_done[1]), 32'(W4 + 2));
    end
    idle_cycles(8);

    // Random traffic on both instances until 1000 WIDTH=4 results.
    d0 = done_cnt4;
    for (int i = 0; i < 15000 && (done_cnt4 - d0) < 1000; i++) begin
      @(negedge clk);
      bus4.start = ($urandom_range(0, 3) != 0);
      bus4.a     = 4'($urandom_range(0, 15));
      bus4.b     = 4'($urandom_range(0, 15));
      bus8.start = ($urandom_range(0, 3) != 0);
      bus8.a     = 8'($urandom_range(0, 255));
      bus8.b     = 8'($urandom_range(0, 255));
    end
    bus4.start = 1'b0;
    bus8.start = 1'b0;
    chk("rand_count", 32'((done_cnt4 - d0) >= 1000), 32'd1);
    idle_cycles(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
